// File: rtl/twiddle_server.sv
// Twiddle-factor table with a LOADING/READY handshake and a two-stage registered read pipeline.
// Optional build macro TWIDDLE_CONJ_EN returns the conjugate (saturating negated imaginary part).
module twiddle_server #(
  parameter int unsigned WORDSIZE = 16,
  parameter int unsigned ADDRSIZE = 5,
  parameter int unsigned NUMADDR  = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cs,
  input  logic [ADDRSIZE-1:0] addr,
  input  logic                ld_start,
  input  logic                ld_en,
  input  logic [ADDRSIZE-1:0] ld_addr,
  input  logic [WORDSIZE-1:0] ld_data_r,
  input  logic [WORDSIZE-1:0] ld_data_i,
  output logic [WORDSIZE-1:0] twiddle_r,
  output logic [WORDSIZE-1:0] twiddle_i,
  output logic                valid,
  output logic                ready,
  output logic                err
);

  localparam logic [ADDRSIZE-1:0] LAST_ADDR = ADDRSIZE'(NUMADDR - 1);
  localparam logic [WORDSIZE-1:0] MOST_NEG  = {1'b1, {(WORDSIZE-1){1'b0}}};
  localparam logic [WORDSIZE-1:0] MOST_POS  = ~MOST_NEG;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    READY   = 2'd2
  } state_e;

  state_e              state_q;
  logic                ready_q;
  logic                err_q;
  logic                s1_vld_q;
  logic [ADDRSIZE-1:0] s1_addr_q;
  logic                valid_q;
  logic [WORDSIZE-1:0] tw_r_q;
  logic [WORDSIZE-1:0] tw_i_q;

  logic [WORDSIZE-1:0] mem_r_q [NUMADDR];
  logic [WORDSIZE-1:0] mem_i_q [NUMADDR];

  logic                rd_acc_c;
  logic                rd_rej_c;
  logic                wr_acc_c;
  logic                wr_rej_c;
  logic [WORDSIZE-1:0] imag_rd_c;
  logic [WORDSIZE-1:0] imag_out_c;

  // Request qualification uses the state at the request cycle.
  always_comb begin
    rd_acc_c = cs && (state_q == READY) && (32'(addr) < NUMADDR);
    rd_rej_c = cs && !rd_acc_c;
    wr_acc_c = ld_en && (state_q == LOADING) && (32'(ld_addr) < NUMADDR);
    wr_rej_c = ld_en && !wr_acc_c;
  end

  // Control FSM; ld_start has priority over completing a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= rd_rej_c || wr_rej_c;
      if (ld_start) begin
        state_q <= LOADING;
        ready_q <= 1'b0;
      end else if (wr_acc_c && (ld_addr == LAST_ADDR)) begin
        state_q <= READY;
        ready_q <= 1'b1;
      end
    end
  end

  // Table storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc_c) begin
      mem_r_q[ld_addr] <= ld_data_r;
      mem_i_q[ld_addr] <= ld_data_i;
    end
  end

  always_comb begin
    imag_rd_c = mem_i_q[s1_addr_q];
`ifdef TWIDDLE_CONJ_EN
    imag_out_c = (imag_rd_c == MOST_NEG) ? MOST_POS : (~imag_rd_c + WORDSIZE'(1));
`else
    imag_out_c = imag_rd_c;
`endif
  end

  // Stage 1 registers the address, stage 2 registers the data; outputs hold between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_addr_q <= '0;
      valid_q   <= 1'b0;
      tw_r_q    <= '0;
      tw_i_q    <= '0;
    end else begin
      s1_vld_q <= rd_acc_c;
      if (rd_acc_c) begin
        s1_addr_q <= addr;
      end
      valid_q <= s1_vld_q;
      if (s1_vld_q) begin
        tw_r_q <= mem_r_q[s1_addr_q];
        tw_i_q <= imag_out_c;
      end
    end
  end

  assign twiddle_r = tw_r_q;
  assign twiddle_i = tw_i_q;
  assign valid     = valid_q;
  assign ready     = ready_q;
  assign err       = err_q;

endmodule

// File: tb/tb_twiddle_server.sv
// Directed and randomized bench for twiddle_server against a transaction-level table model.
module tb_twiddle_server;

  localparam int unsigned W = 16;
  localparam int unsigned A = 5;
  localparam int unsigned N = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cs = 1'b0;
  logic [A-1:0] addr = '0;
  logic         ld_start = 1'b0;
  logic         ld_en = 1'b0;
  logic [A-1:0] ld_addr = '0;
  logic [W-1:0] ld_data_r = '0;
  logic [W-1:0] ld_data_i = '0;
  logic [W-1:0] twiddle_r;
  logic [W-1:0] twiddle_i;
  logic         valid;
  logic         ready;
  logic         err;

  twiddle_server #(.WORDSIZE(W), .ADDRSIZE(A), .NUMADDR(N)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .addr(addr),
    .ld_start(ld_start), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data_r(ld_data_r), .ld_data_i(ld_data_i),
    .twiddle_r(twiddle_r), .twiddle_i(twiddle_i),
    .valid(valid), .ready(ready), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           due;
    logic [W-1:0] r;
    logic [W-1:0] i;
  } pend_t;

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           mode = 0;  // 0 empty, 1 loading, 2 ready
  logic [W-1:0] tbl_r [N];
  logic [W-1:0] tbl_i [N];
  pend_t        pipe [$];
  logic [W-1:0] exp_r = '0;
  logic [W-1:0] exp_i = '0;
  logic         exp_valid = 1'b0;
  logic         exp_err = 1'b0;
  logic [W-1:0] dr_a [N];
  logic [W-1:0] di_a [N];
  int           ord_a [N];

  // Expected imaginary output for a stored value, computed as a signed integer.
  function automatic logic [W-1:0] imag_ref(input logic [W-1:0] v);
`ifdef TWIDDLE_CONJ_EN
    int s;
    s = -int'($signed(v));
    if (s > 32767) s = 32767;
    return W'(s);
`else
    return v;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_valid"}, 32'(valid), 32'(exp_valid));
    chk({tag, "_ready"}, 32'(ready), 32'(mode == 2));
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_tw_r"}, 32'(twiddle_r), 32'(exp_r));
    chk({tag, "_tw_i"}, 32'(twiddle_i), 32'(exp_i));
  endtask

  task automatic step(input string tag, input logic c, input logic [A-1:0] a, input logic ls,
                      input logic le, input logic [A-1:0] la, input logic [W-1:0] dr,
                      input logic [W-1:0] di);
    bit    acc;
    bit    nerr;
    int    nmode;
    pend_t p;
    cs = c; addr = a; ld_start = ls; ld_en = le; ld_addr = la; ld_data_r = dr; ld_data_i = di;
    acc  = c && (mode == 2) && (int'(a) < int'(N));
    nerr = (c && !acc) || (le && !((mode == 1) && (int'(la) < int'(N))));
    if (acc) pipe.push_back('{due: cyc + 2, r: tbl_r[a], i: imag_ref(tbl_i[a])});
    nmode = mode;
    if (le && (mode == 1) && (int'(la) < int'(N))) begin
      tbl_r[la] = dr;
      tbl_i[la] = di;
      if (int'(la) == int'(N) - 1) nmode = 2;
    end
    if (ls) nmode = 1;
    @(posedge clk);
    #1;
    cyc++;
    mode = nmode;
    exp_err = nerr;
    exp_valid = 1'b0;
    if (pipe.size() > 0 && pipe[0].due == cyc) begin
      p = pipe.pop_front();
      exp_valid = 1'b1;
      exp_r = p.r;
      exp_i = p.i;
    end
    check_all(tag);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step("idle", 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    cs = 1'b0; ld_start = 1'b0; ld_en = 1'b0;
    pipe.delete();
    mode = 0; exp_valid = 1'b0; exp_err = 1'b0; exp_r = '0; exp_i = '0;
    #2;
    check_all({tag, "_async"});
    @(posedge clk);
    #1;
    cyc++;
    check_all({tag, "_held"});
    rst_n = 1'b1;
  endtask

  // Writes entries in the given order; optional read noise issues rejected reads alongside.
  task automatic write_entries(input string tag, input bit noise);
    logic c;
    for (int k = 0; k < int'(N); k++) begin
      c = noise && ($urandom_range(0, 99) < 30);
      step(tag, c, A'($urandom), 1'b0, 1'b1, A'(ord_a[k]), dr_a[ord_a[k]], di_a[ord_a[k]]);
    end
  endtask

  task automatic rand_reload(input string tag, input logic with_cs);
    int j;
    int t;
    for (int k = 0; k < int'(N); k++) begin
      dr_a[k] = W'($urandom);
      di_a[k] = ($urandom_range(0, 9) == 0) ? 16'h8000 : W'($urandom);
      ord_a[k] = k;
    end
    for (int k = int'(N) - 2; k > 0; k--) begin
      j = int'($urandom_range(0, k));
      t = ord_a[k]; ord_a[k] = ord_a[j]; ord_a[j] = t;
    end
    step({tag, "_start"}, with_cs, A'($urandom), 1'b1, 1'b0, '0, '0, '0);
    write_entries(tag, 1'b1);
  endtask

  logic [W-1:0] e37;
  int           op;

  initial begin
    // Reset, then a read in EMPTY is rejected.
    do_reset("rst0");
    idle(1);
    step("r33_cs", 1'b1, '0, 1'b0, 1'b0, '0, '0, '0);
    chk("r33_err", 32'(err), 32'd1);
    idle(2);

    // Ramp table, then three back-to-back reads.
    for (int k = 0; k < int'(N); k++) begin
      dr_a[k] = W'(k); di_a[k] = W'(-k); ord_a[k] = k;
    end
    step("r34_start", 1'b0, '0, 1'b1, 1'b0, '0, '0, '0);
    write_entries("r34_ld", 1'b0);
    step("r34_cs5", 1'b1, A'(5), 1'b0, 1'b0, '0, '0, '0);
    step("r34_cs6", 1'b1, A'(6), 1'b0, 1'b0, '0, '0, '0);
    chk("r34_d5r", 32'(twiddle_r), 32'd5);
    chk("r34_d5i", 32'(twiddle_i), 32'(imag_ref(16'hFFFB)));
    step("r34_cs7", 1'b1, A'(7), 1'b0, 1'b0, '0, '0, '0);
    idle(1);
    chk("r34_d7r", 32'(twiddle_r), 32'd7);
    idle(2);

    // Read together with ld_start returns the pre-reload entry.
    step("r35_both", 1'b1, A'(3), 1'b1, 1'b0, '0, '0, '0);
    chk("r35_ready", 32'(ready), 32'd0);
    step("r35_wr3", 1'b0, '0, 1'b0, 1'b1, A'(3), 16'h7FFF, 16'h7FFF);
    chk("r35_old", 32'(twiddle_r), 32'd3);
    dr_a[3] = 16'h7FFF; di_a[3] = 16'h7FFF;
    write_entries("r35_ld", 1'b0);
    step("r35_rd3", 1'b1, A'(3), 1'b0, 1'b0, '0, '0, '0);
    idle(2);

    // Most-negative imaginary value.
    step("r37_start", 1'b0, '0, 1'b1, 1'b0, '0, '0, '0);
    step("r37_wr4", 1'b0, '0, 1'b0, 1'b1, A'(4), 16'h1234, 16'h8000);
    step("r37_wr31", 1'b0, '0, 1'b0, 1'b1, A'(31), 16'd31, 16'hFFE1);
    step("r37_rd4", 1'b1, A'(4), 1'b0, 1'b0, '0, '0, '0);
    idle(1);
`ifdef TWIDDLE_CONJ_EN
    e37 = 16'h7FFF;
`else
    e37 = 16'h8000;
`endif
    chk("r37_imag", 32'(twiddle_i), 32'(e37));

    // Write attempted while READY is rejected and leaves the table alone.
    step("r36_wr", 1'b0, '0, 1'b0, 1'b1, A'(2), 16'hAAAA, 16'h5555);
    chk("r36_err", 32'(err), 32'd1);
    step("r36_rd2", 1'b1, A'(2), 1'b0, 1'b0, '0, '0, '0);
    idle(1);
    chk("r36_keep", 32'(twiddle_r), 32'd2);
    idle(1);

    // Reset while a read is in flight.
    step("r38_cs", 1'b1, A'(9), 1'b0, 1'b0, '0, '0, '0);
    do_reset("r38_rst");
    idle(4);
    chk("r38_ready", 32'(ready), 32'd0);
    step("r38_rd", 1'b1, A'(9), 1'b0, 1'b0, '0, '0, '0);
    idle(2);

    // Randomized traffic.
    rand_reload("rnd_ld", 1'b0);
    for (int n = 0; n < 500; n++) begin
      op = int'($urandom_range(0, 99));
      if (op < 70) begin
        step("rnd_rd", 1'b1, A'($urandom), 1'b0, 1'b0, '0, '0, '0);
      end else if (op < 80) begin
        step("rnd_badwr", $urandom_range(0, 1) == 1, A'($urandom), 1'b0, 1'b1, A'($urandom),
             W'($urandom), W'($urandom));
      end else if (op < 84) begin
        rand_reload("rnd_reld", $urandom_range(0, 1) == 1);
      end else if (op < 86) begin
        do_reset("rnd_rst");
        rand_reload("rnd_rld", 1'b1);
      end else begin
        idle(1);
      end
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
